// File: rtl/regfile_writeback_buffer.sv
// Queues ALU/load register writes and drains one per cycle onto the register-file write port (1-cycle FIFO-to-port latency).
// Upstream is held off whenever fewer than two slots are free; pending values are exposed through a combinational bypass.
module regfile_writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       mem_valid,
    input  logic [ADDR_W-1:0]          mem_rd,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       in_ready,
    output logic                       rf_regWrite,
    output logic [ADDR_W-1:0]          rf_writeRegister,
    output logic [DATA_W-1:0]          rf_writeData,
    input  logic [ADDR_W-1:0]          lookup_rs,
    input  logic [ADDR_W-1:0]          lookup_rt,
    output logic                       rs_hit,
    output logic [DATA_W-1:0]          rs_data,
    output logic                       rt_hit,
    output logic [DATA_W-1:0]          rt_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rf_regWrite_q;
    logic [ADDR_W-1:0] rf_writeRegister_q;
    logic [DATA_W-1:0] rf_writeData_q;

    logic              store_mem, store_alu, pop;
    logic [CNT_W-1:0]  n_store;
    logic [PTR_W-1:0]  alu_slot;
    logic [PTR_W-1:0]  idx;

    // Ready ignores a same-cycle pop so it depends on registered state only.
    assign in_ready  = (DEPTH - int'(count_q)) >= 2;
    assign store_mem = in_ready && mem_valid && (mem_rd != '0);
    assign store_alu = in_ready && alu_valid && (alu_rd != '0);
    assign pop       = (count_q != '0);
    assign n_store   = CNT_W'(store_mem) + CNT_W'(store_alu);
    assign alu_slot  = tail_q + PTR_W'(store_mem);
    assign count_d   = count_q + n_store - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            rf_regWrite_q      <= 1'b0;
            rf_writeRegister_q <= '0;
            rf_writeData_q     <= '0;
        end else begin
            if (pop) begin
                rf_regWrite_q      <= 1'b1;
                rf_writeRegister_q <= rd_q[head_q];
                rf_writeData_q     <= data_q[head_q];
                head_q             <= head_q + PTR_W'(1);
            end else begin
                rf_regWrite_q      <= 1'b0;
            end
            if (store_mem) begin
                rd_q[tail_q]   <= mem_rd;
                data_q[tail_q] <= mem_data;
            end
            if (store_alu) begin
                rd_q[alu_slot]   <= alu_rd;
                data_q[alu_slot] <= alu_data;
            end
            tail_q  <= tail_q + PTR_W'(n_store);
            count_q <= count_d;
        end
    end

    // Scan oldest to youngest so later matches override earlier ones.
    always_comb begin
        rs_hit  = 1'b0;
        rs_data = '0;
        rt_hit  = 1'b0;
        rt_data = '0;
        idx     = head_q;
        if (rf_regWrite_q) begin
            if (rf_writeRegister_q == lookup_rs) begin
                rs_hit  = 1'b1;
                rs_data = rf_writeData_q;
            end
            if (rf_writeRegister_q == lookup_rt) begin
                rt_hit  = 1'b1;
                rt_data = rf_writeData_q;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (rd_q[idx] == lookup_rs) begin
                    rs_hit  = 1'b1;
                    rs_data = data_q[idx];
                end
                if (rd_q[idx] == lookup_rt) begin
                    rt_hit  = 1'b1;
                    rt_data = data_q[idx];
                end
            end
        end
        if (lookup_rs == '0) begin
            rs_hit  = 1'b0;
            rs_data = '0;
        end
        if (lookup_rt == '0) begin
            rt_hit  = 1'b0;
            rt_data = '0;
        end
    end

    assign rf_regWrite      = rf_regWrite_q;
    assign rf_writeRegister = rf_writeRegister_q;
    assign rf_writeData     = rf_writeData_q;
    assign count            = count_q;

endmodule

// File: tb/tb_regfile_writeback_buffer.sv
// Directed bench for regfile_writeback_buffer: reset, single/dual writes, rd=0 filter, backpressure, reset mid-drain.
module tb_regfile_writeback_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid, mem_valid;
    logic [ADDR_W-1:0] alu_rd, mem_rd;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              in_ready;
    logic              rf_regWrite;
    logic [ADDR_W-1:0] rf_writeRegister;
    logic [DATA_W-1:0] rf_writeData;
    logic [ADDR_W-1:0] lookup_rs, lookup_rt;
    logic              rs_hit, rt_hit;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic [CNT_W-1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_writeback_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .in_ready(in_ready),
        .rf_regWrite(rf_regWrite), .rf_writeRegister(rf_writeRegister), .rf_writeData(rf_writeData),
        .lookup_rs(lookup_rs), .lookup_rt(lookup_rt),
        .rs_hit(rs_hit), .rs_data(rs_data), .rt_hit(rt_hit), .rt_data(rt_data),
        .count(count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        lookup_rs = '0; lookup_rt = '0;
        tick(); tick();
        reset = 1'b0;
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (rf_regWrite !== 1'b0) begin n_fail++; $display("FAIL idle_regwrite cyc %0d: got %b expected 0", c, rf_regWrite); end
        end
        for (int r = 0; r < 32; r++) begin
            lookup_rs = ADDR_W'(r);
            lookup_rt = ADDR_W'(31 - r);
            #1;
            n_checks++;
            if (rs_hit !== 1'b0 || rt_hit !== 1'b0) begin
                n_fail++; $display("FAIL idle_lookup r=%0d: got rs_hit=%b rt_hit=%b expected 0 0", r, rs_hit, rt_hit);
            end
        end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        tick();
        idle_inputs();
        lookup_rs = 5'd5;
        #1;
        n_checks++;
        if (count !== 3'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", count); end
        n_checks++;
        if (rf_regWrite !== 1'b0) begin n_fail++; $display("FAIL single_early_write: got %b expected 0", rf_regWrite); end
        n_checks++;
        if (rs_hit !== 1'b1 || rs_data !== 32'h1234) begin
            n_fail++; $display("FAIL single_bypass_fifo: got hit=%b data=%h expected 1 00001234", rs_hit, rs_data);
        end
        tick();
        n_checks++;
        if (rf_regWrite !== 1'b1 || rf_writeRegister !== 5'd5 || rf_writeData !== 32'h1234) begin
            n_fail++; $display("FAIL single_drain: got we=%b rd=%0d data=%h expected 1 5 00001234", rf_regWrite, rf_writeRegister, rf_writeData);
        end
        n_checks++;
        if (rs_hit !== 1'b1 || rs_data !== 32'h1234) begin
            n_fail++; $display("FAIL single_bypass_inflight: got hit=%b data=%h expected 1 00001234", rs_hit, rs_data);
        end
        tick();
        n_checks++;
        if (count !== 3'd0 || rf_regWrite !== 1'b0) begin
            n_fail++; $display("FAIL single_done: got count=%0d we=%b expected 0 0", count, rf_regWrite);
        end
        n_checks++;
        if (rs_hit !== 1'b0) begin n_fail++; $display("FAIL single_bypass_after: got hit=%b expected 0", rs_hit); end
    endtask

    task automatic test_dual_same_rd();
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hAA;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hBB;
        tick();
        idle_inputs();
        lookup_rs = 5'd3;
        #1;
        n_checks++;
        if (count !== 3'd2) begin n_fail++; $display("FAIL dual_count: got %0d expected 2", count); end
        n_checks++;
        if (rs_hit !== 1'b1 || rs_data !== 32'hBB) begin
            n_fail++; $display("FAIL dual_bypass_youngest: got hit=%b data=%h expected 1 000000bb", rs_hit, rs_data);
        end
        tick();
        n_checks++;
        if (rf_regWrite !== 1'b1 || rf_writeRegister !== 5'd3 || rf_writeData !== 32'hAA) begin
            n_fail++; $display("FAIL dual_first: got we=%b rd=%0d data=%h expected 1 3 000000aa", rf_regWrite, rf_writeRegister, rf_writeData);
        end
        n_checks++;
        if (rs_hit !== 1'b1 || rs_data !== 32'hBB) begin
            n_fail++; $display("FAIL dual_bypass_over_inflight: got hit=%b data=%h expected 1 000000bb", rs_hit, rs_data);
        end
        tick();
        n_checks++;
        if (rf_regWrite !== 1'b1 || rf_writeRegister !== 5'd3 || rf_writeData !== 32'hBB) begin
            n_fail++; $display("FAIL dual_second: got we=%b rd=%0d data=%h expected 1 3 000000bb", rf_regWrite, rf_writeRegister, rf_writeData);
        end
        tick();
        n_checks++;
        if (rf_regWrite !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL dual_done: got we=%b count=%0d expected 0 0", rf_regWrite, count);
        end
    endtask

    task automatic test_rd0_filter();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h7;
        tick();
        idle_inputs();
        lookup_rs = 5'd7;
        lookup_rt = 5'd0;
        #1;
        n_checks++;
        if (count !== 3'd1) begin n_fail++; $display("FAIL rd0_count: got %0d expected 1", count); end
        n_checks++;
        if (rt_hit !== 1'b0 || rt_data !== 32'h0) begin
            n_fail++; $display("FAIL rd0_lookup: got hit=%b data=%h expected 0 00000000", rt_hit, rt_data);
        end
        n_checks++;
        if (rs_hit !== 1'b1 || rs_data !== 32'h7) begin
            n_fail++; $display("FAIL rd0_lookup7: got hit=%b data=%h expected 1 00000007", rs_hit, rs_data);
        end
        tick();
        n_checks++;
        if (rf_regWrite !== 1'b1 || rf_writeRegister !== 5'd7 || rf_writeData !== 32'h7) begin
            n_fail++; $display("FAIL rd0_drain: got we=%b rd=%0d data=%h expected 1 7 00000007", rf_regWrite, rf_writeRegister, rf_writeData);
        end
        tick();
        n_checks++;
        if (rf_regWrite !== 1'b0) begin n_fail++; $display("FAIL rd0_no_second: got we=%b expected 0", rf_regWrite); end
    endtask

    // Dual requests every cycle for 8 cycles, then drain; expected ready pattern
    // from empty with DEPTH=4 is 1,1,0,1,0,1,0,1 (count alternates 2/3).
    task automatic test_backpressure();
        logic [ADDR_W+DATA_W-1:0] expq[$];
        logic [ADDR_W+DATA_W-1:0] e;
        logic exp_ready [8];
        int cnt;
        int emitted;
        int accepted;
        exp_ready = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        cnt = 0; emitted = 0; accepted = 0;
        for (int k = 0; k < 14; k++) begin
            bit popped;
            if (k < 8) begin
                mem_valid = 1'b1; mem_rd = ADDR_W'(1 + 2 * k); mem_data = 32'hA000 + k;
                alu_valid = 1'b1; alu_rd = ADDR_W'(2 + 2 * k); alu_data = 32'hB000 + k;
                #1;
                n_checks++;
                if (in_ready !== exp_ready[k]) begin
                    n_fail++; $display("FAIL bp_ready cyc %0d: got %b expected %b", k, in_ready, exp_ready[k]);
                end
                if (exp_ready[k]) begin
                    expq.push_back({mem_rd, mem_data});
                    expq.push_back({alu_rd, alu_data});
                    accepted += 2;
                end
            end else begin
                idle_inputs();
            end
            popped = (cnt > 0);
            cnt = cnt + ((k < 8 && exp_ready[k]) ? 2 : 0) - (popped ? 1 : 0);
            tick();
            n_checks++;
            if (count !== CNT_W'(cnt)) begin n_fail++; $display("FAIL bp_count cyc %0d: got %0d expected %0d", k, count, cnt); end
            n_checks++;
            if (rf_regWrite !== popped) begin
                n_fail++; $display("FAIL bp_regwrite cyc %0d: got %b expected %b", k, rf_regWrite, popped);
            end else if (popped) begin
                e = expq.pop_front();
                emitted++;
                if ({rf_writeRegister, rf_writeData} !== e) begin
                    n_fail++; $display("FAIL bp_order cyc %0d: got rd=%0d data=%h expected rd=%0d data=%h",
                                       k, rf_writeRegister, rf_writeData, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
        n_checks++;
        if (emitted !== 10 || accepted !== 10) begin
            n_fail++; $display("FAIL bp_total: got emitted=%0d accepted=%0d expected 10 10", emitted, accepted);
        end
    endtask

    task automatic test_reset_mid_drain();
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'h10;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h11;
        tick();
        mem_rd = 5'd12; mem_data = 32'h12;
        alu_rd = 5'd13; alu_data = 32'h13;
        tick();
        n_checks++;
        if (count !== 3'd3 || rf_regWrite !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre: got count=%0d we=%b expected 3 1", count, rf_regWrite);
        end
        reset = 1'b1;
        mem_rd = 5'd14; mem_data = 32'h14;
        alu_rd = 5'd15; alu_data = 32'h15;
        tick();
        reset = 1'b0;
        idle_inputs();
        lookup_rs = 5'd12;
        lookup_rt = 5'd14;
        #1;
        n_checks++;
        if (count !== 3'd0 || rf_regWrite !== 1'b0 || rf_writeRegister !== 5'd0 || rf_writeData !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_state: got count=%0d we=%b rd=%0d data=%h expected 0 0 0 0",
                               count, rf_regWrite, rf_writeRegister, rf_writeData);
        end
        n_checks++;
        if (rs_hit !== 1'b0 || rt_hit !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_lookup: got rs_hit=%b rt_hit=%b expected 0 0", rs_hit, rt_hit);
        end
        tick();
        n_checks++;
        if (rf_regWrite !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL rst_mid_dropped: got we=%b count=%0d expected 0 0", rf_regWrite, count);
        end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        idle_inputs();
        n_checks++;
        if (count !== 3'd1) begin n_fail++; $display("FAIL rst_post_count: got %0d expected 1", count); end
        tick();
        n_checks++;
        if (rf_regWrite !== 1'b1 || rf_writeRegister !== 5'd9 || rf_writeData !== 32'h99) begin
            n_fail++; $display("FAIL rst_post_drain: got we=%b rd=%0d data=%h expected 1 9 00000099", rf_regWrite, rf_writeRegister, rf_writeData);
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_dual_same_rd();
        test_rd0_filter();
        test_backpressure();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_buffer.md
Name: regfile_writeback_buffer

Overview:
Write-side initiator for the 32x32 register file. It collects register-write requests from the ALU and load paths and queues them in a small FIFO. It drains one write per cycle onto the register file's regWrite/writeRegister/writeData port. It also provides a bypass lookup so decode can read values that are queued but not yet committed.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 5, register index width
DATA_W, 32, register data width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
alu_valid  in  1  ALU write request
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load write request
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
in_ready  out  1  both request slots can be accepted this cycle
rf_regWrite  out  1  to register file regWrite (registered)
rf_writeRegister  out  ADDR_W  to register file writeRegister (registered)
rf_writeData  out  DATA_W  to register file writeData (registered)
lookup_rs  in  ADDR_W  first bypass query index
lookup_rt  in  ADDR_W  second bypass query index
rs_hit  out  1  pending write exists for lookup_rs
rs_data  out  DATA_W  youngest pending value for lookup_rs
rt_hit  out  1  pending write exists for lookup_rt
rt_data  out  DATA_W  youngest pending value for lookup_rt
count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is synchronous and active-high on clk. At a reset edge:
  - FIFO is emptied (count=0, head/tail pointers=0).
  - rf_regWrite=0, rf_writeRegister=0, rf_writeData=0.
  - Requests presented in the same cycle as reset are dropped.
  - Reset mid-drain loses all queued writes. This is intended, because the register file reinitialises on the same reset.
- in_ready = (DEPTH - count) >= 2.
  - It is combinational from count only and does not credit a same-cycle dequeue.
  - When in_ready=0, both requests are ignored; the upstream stage holds them.
- Enqueue when in_ready=1:
  - A request is stored only if valid=1 and rd!=0. Requests with rd=0 are silently discarded, since register 0 is hardwired.
  - If both are stored in one cycle, the mem entry goes in first (older) and the alu entry second.
  - Tail advances by the number stored (0, 1 or 2). Pointers wrap modulo DEPTH.
- Dequeue: every cycle that count>0 (count sampled before this edge's enqueue):
  - The head entry is popped into the rf_* output registers with rf_regWrite=1.
  - If count==0, rf_regWrite=0. rf_writeRegister and rf_writeData hold their last values.
- Simultaneous enqueue and dequeue: count_next = count + stored - popped. Count never exceeds DEPTH and never underflows.
- Latency: a request accepted at edge N appears on the rf_* outputs after edge N+1 if the FIFO was empty. The register file commits it at edge N+2.
- The register file read data is registered and samples before write. A value is therefore architecturally visible from register-file reads issued at edge N+3 onward.
- Bypass lookup is combinational and covers all valid FIFO entries plus the in-flight output register (when rf_regWrite=1).
  - Priority: youngest FIFO entry (nearest tail) > older FIFO entries > in-flight output.
  - hit=0 and data=0 when there is no match or the lookup index is 0.
  - Same-cycle incoming requests are not visible to lookup.
- Ordering: writes reach the register file strictly in acceptance order. Multiple pending writes to the same rd are all performed; the last one wins in the register file.

Test Plan:
- Reset then idle: count=0, in_ready=1, rf_regWrite=0 every cycle, rs_hit=rt_hit=0 for all indices.
- Single ALU write rd=5, data=0x1234 at edge 1: count=1 after edge 1. rf_regWrite=1, rf_writeRegister=5, rf_writeData=0x1234 after edge 2. count=0 and rf_regWrite=0 after edge 3.
- Dual request mem rd=3 data=0xAA and alu rd=3 data=0xBB in one cycle: the drain emits 3/0xAA then 3/0xBB. Before the drain, lookup_rs=3 gives rs_hit=1, rs_data=0xBB.
- rd=0 filtering: alu rd=0 data=0xFFFF plus mem rd=7 data=0x7: count increments by exactly 1 and only rd=7 is written. lookup_rt=0 gives rt_hit=0.
- Backpressure: stall the drain path by issuing dual requests every cycle from empty. in_ready drops when count>=3 (DEPTH=4) and requests presented while in_ready=0 are not stored. All accepted writes then emerge in order with no loss or duplication, and pointer wrap is exercised.
- Reset mid-operation: with count=3 and rf_regWrite=1, assert reset for one cycle. After that edge, count=0 and rf_regWrite=0, and lookups miss. A new request after reset drains normally.
